// File: rtl/depthwise_conv3x3_stream_pkg.sv
// Shared definitions for the depthwise 3x3 streaming convolution engine:
// window tap indices, output-dimension helpers and signed saturation.
package depthwise_conv3x3_stream_pkg;

    localparam int TAPS = 9;

    // Tap index t = 3*row + col inside the 3x3 window (row 0 is the oldest line)
    localparam int TAP_TL = 0;
    localparam int TAP_TC = 1;
    localparam int TAP_TR = 2;
    localparam int TAP_ML = 3;
    localparam int TAP_MC = 4;
    localparam int TAP_MR = 5;
    localparam int TAP_BL = 6;
    localparam int TAP_BC = 7;
    localparam int TAP_BR = 8;

    function automatic int calc_ow(input int img_w, input int stride);
        return (img_w - 3) / stride + 1;
    endfunction

    function automatic int calc_oh(input int img_h, input int stride);
        return (img_h - 3) / stride + 1;
    endfunction

    // Clamp v into the signed range of a w-bit number (w <= 64)
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/depthwise_conv3x3_stream_line_buffer.sv
// Two-line delay for the 3x3 window: tap_row1 is the pixel one line above
// the incoming one, tap_row2 the pixel two lines above.
module conv_line_buffer
    import depthwise_conv3x3_stream_pkg::*;
#(
    parameter int IMG_W = 44,
    parameter int PIX_W = 256
) (
    input  logic             clk,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] tap_row1,
    output logic [PIX_W-1:0] tap_row2
);

    logic [PIX_W-1:0] row1_q [IMG_W];
    logic [PIX_W-1:0] row2_q [IMG_W];

    // Contents are not reset: alignment comes from shifting once per accepted beat
    always_ff @(posedge clk) begin
        if (en) begin
            row1_q[0] <= din;
            row2_q[0] <= row1_q[IMG_W-1];
            for (int i = 1; i < IMG_W; i++) begin
                row1_q[i] <= row1_q[i-1];
                row2_q[i] <= row2_q[i-1];
            end
        end
    end

    assign tap_row1 = row1_q[IMG_W-1];
    assign tap_row2 = row2_q[IMG_W-1];

endmodule

// File: rtl/depthwise_conv3x3_stream.sv
// Depthwise 3x3 convolution over a raster pixel stream, all channels in
// parallel, with valid/ready flow control and per-frame coefficients.
module depthwise_conv3x3_stream
    import depthwise_conv3x3_stream_pkg::*;
#(
    parameter int CH     = 16,
    parameter int DATA_W = 16,
    parameter int COEF_W = 8,
    parameter int FRAC   = 0,
    parameter int IMG_W  = 44,
    parameter int IMG_H  = 44,
    parameter int STRIDE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CH*DATA_W-1:0]         in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CH*TAPS*COEF_W-1:0]    coef,
    output logic [CH*DATA_W-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last
);

    localparam int PIX_W    = CH * DATA_W;
    localparam int PROD_W   = DATA_W + COEF_W;
    localparam int SUM_W    = PROD_W + 4;
    localparam int OW       = calc_ow(IMG_W, STRIDE);
    localparam int OH       = calc_oh(IMG_H, STRIDE);
    localparam int LAST_ROW = 2 + (OH - 1) * STRIDE;
    localparam int LAST_COL = 2 + (OW - 1) * STRIDE;
    localparam int ROW_W    = $clog2(IMG_H);
    localparam int COL_W    = $clog2(IMG_W);

    logic [ROW_W-1:0]          row;
    logic [COL_W-1:0]          col;
    logic [CH*TAPS*COEF_W-1:0] coef_q;
    logic                      advance;
    logic                      accept;
    logic                      stride_ok;
    logic                      launch;
    logic                      is_last_win;
    logic [PIX_W-1:0]          tap_row1;
    logic [PIX_W-1:0]          tap_row2;
    logic [PIX_W-1:0]          win_q    [TAPS];
    logic [PIX_W-1:0]          win_next [TAPS];
    logic signed [PROD_W-1:0]  prod_next [CH][TAPS];
    logic signed [PROD_W-1:0]  prod_q    [CH][TAPS];
    logic signed [SUM_W-1:0]   sum_next  [CH];
    logic signed [SUM_W-1:0]   sum_q     [CH];
    logic [PIX_W-1:0]          out_next;
    logic                      v1;
    logic                      l1;
    logic                      v2;
    logic                      l2;

    assign advance     = !out_valid || out_ready;
    assign in_ready    = advance;
    assign accept      = in_valid && advance;
    assign stride_ok   = (STRIDE == 1) || (!row[0] && !col[0]);
    assign launch      = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2)) && stride_ok;
    assign is_last_win = (row == ROW_W'(LAST_ROW)) && (col == COL_W'(LAST_COL));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row    <= '0;
            col    <= '0;
            coef_q <= '0;
        end else if (accept) begin
            if (row == '0 && col == '0) begin
                coef_q <= coef;
            end
            if (col == COL_W'(IMG_W - 1)) begin
                col <= '0;
                row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    conv_line_buffer #(
        .IMG_W (IMG_W),
        .PIX_W (PIX_W)
    ) u_line_buffer (
        .clk      (clk),
        .en       (accept),
        .din      (in_data),
        .tap_row1 (tap_row1),
        .tap_row2 (tap_row2)
    );

    // Window as it will look after this beat; products are taken from it directly
    always_comb begin
        win_next[TAP_TL] = win_q[TAP_TC];
        win_next[TAP_TC] = win_q[TAP_TR];
        win_next[TAP_TR] = tap_row2;
        win_next[TAP_ML] = win_q[TAP_MC];
        win_next[TAP_MC] = win_q[TAP_MR];
        win_next[TAP_MR] = tap_row1;
        win_next[TAP_BL] = win_q[TAP_BC];
        win_next[TAP_BC] = win_q[TAP_BR];
        win_next[TAP_BR] = in_data;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            win_q <= win_next;
        end
    end

    always_comb begin
        logic [DATA_W-1:0] px;
        logic [COEF_W-1:0] cf;
        px = '0;
        cf = '0;
        for (int k = 0; k < CH; k++) begin
            for (int t = 0; t < TAPS; t++) begin
                px = win_next[t][k*DATA_W +: DATA_W];
                cf = coef_q[(TAPS*k + t)*COEF_W +: COEF_W];
                prod_next[k][t] = $signed({{COEF_W{px[DATA_W-1]}}, px})
                                * $signed({{DATA_W{cf[COEF_W-1]}}, cf});
            end
        end
    end

    always_comb begin
        for (int k = 0; k < CH; k++) begin
            sum_next[k] = '0;
            for (int t = 0; t < TAPS; t++) begin
                sum_next[k] = sum_next[k] + {{4{prod_q[k][t][PROD_W-1]}}, prod_q[k][t]};
            end
        end
    end

    // Floor shift then clamp to the pixel range
    always_comb begin
        logic signed [SUM_W-1:0] shifted;
        shifted  = '0;
        out_next = '0;
        for (int k = 0; k < CH; k++) begin
            shifted = sum_q[k] >>> FRAC;
            out_next[k*DATA_W +: DATA_W] = DATA_W'(sat_signed(64'(shifted), DATA_W));
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            prod_q <= prod_next;
            sum_q  <= sum_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1        <= 1'b0;
            l1        <= 1'b0;
            v2        <= 1'b0;
            l2        <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            v1        <= launch;
            l1        <= launch && is_last_win;
            v2        <= v1;
            l2        <= l1;
            out_valid <= v2;
            out_last  <= l2;
            out_data  <= out_next;
        end
    end

endmodule
